// File: rtl/rvvi_tx_arbiter.sv
// Frame-granular arbiter sharing one 32-bit MAC write channel between two frame sources.
// Define RVVI_TX_PRIO_EN to give source 1 strict priority instead of round-robin.
module rvvi_tx_arbiter #(
  parameter int unsigned MAX_FRAME_WORDS   = 512,
  parameter int unsigned WORD_COUNT_WIDTH  = 10,
  parameter int unsigned FRAME_COUNT_WIDTH = 64,
  parameter int unsigned GAP_WIDTH         = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  S0Wdata,
  input  logic [3:0]                   S0Wstrb,
  input  logic                         S0Wlast,
  input  logic                         S0Wvalid,
  output logic                         S0Wready,
  input  logic [31:0]                  S1Wdata,
  input  logic [3:0]                   S1Wstrb,
  input  logic                         S1Wlast,
  input  logic                         S1Wvalid,
  output logic                         S1Wready,
  output logic [31:0]                  MWdata,
  output logic [3:0]                   MWstrb,
  output logic                         MWlast,
  output logic                         MWvalid,
  input  logic                         MWready,
  input  logic [GAP_WIDTH-1:0]         InterFrameGap,
  input  logic                         ErrClear,
  output logic [1:0]                   Grant,
  output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
  output logic                         ErrLong
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] XFER0 = 3'd1;
  localparam logic [2:0] XFER1 = 3'd2;
  localparam logic [2:0] DROP  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  localparam logic [WORD_COUNT_WIDTH-1:0] LAST_IDX = WORD_COUNT_WIDTH'(MAX_FRAME_WORDS - 1);

  logic [2:0]                   state_q, state_d;
  logic                         owner_q, owner_d;
  logic                         rr_q, rr_d;
  logic [WORD_COUNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [GAP_WIDTH-1:0]         gap_cnt_q, gap_cnt_d;
  logic [FRAME_COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                         err_long_q, err_long_d;

  logic [31:0] src_data;
  logic [3:0]  src_strb;
  logic        src_last, src_valid, src_ready;
  logic        xfer, drop, at_limit, hs, trunc, pick;

  always_comb begin
    src_data  = owner_q ? S1Wdata  : S0Wdata;
    src_strb  = owner_q ? S1Wstrb  : S0Wstrb;
    src_last  = owner_q ? S1Wlast  : S0Wlast;
    src_valid = owner_q ? S1Wvalid : S0Wvalid;
  end

  assign xfer     = (state_q == XFER0) || (state_q == XFER1);
  assign drop     = (state_q == DROP);
  assign at_limit = (word_cnt_q == LAST_IDX);

  assign MWdata    = src_data;
  assign MWstrb    = src_strb;
  assign MWvalid   = xfer & src_valid;
  assign MWlast    = xfer & (src_last | at_limit);
  assign src_ready = xfer ? MWready : drop;
  assign S0Wready  = src_ready & ~owner_q;
  assign S1Wready  = src_ready & owner_q;
  assign Grant     = (xfer | drop) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  assign hs    = MWvalid & MWready;
  assign trunc = hs & at_limit & ~src_last;

  assign FrameCount = frame_count_q;
  assign ErrLong    = err_long_q;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    word_cnt_d    = word_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;
    pick          = 1'b0;
    err_long_d    = trunc | (err_long_q & ~ErrClear);

    case (state_q)
      IDLE: begin
        if (S0Wvalid || S1Wvalid) begin
`ifdef RVVI_TX_PRIO_EN
          pick = S1Wvalid;
`else
          // On a tie, serve whichever source was not granted last.
          pick = S1Wvalid & (~S0Wvalid | ~rr_q);
`endif
          rr_d       = pick;
          owner_d    = pick;
          word_cnt_d = '0;
          state_d    = pick ? XFER1 : XFER0;
        end
      end
      XFER0, XFER1: begin
        if (hs) begin
          if (src_last || at_limit) begin
            gap_cnt_d = InterFrameGap;
            if (!owner_q) frame_count_d = frame_count_q + FRAME_COUNT_WIDTH'(1);
            if (!src_last)                 state_d = DROP;
            else if (InterFrameGap == '0)  state_d = IDLE;
            else                           state_d = GAP;
          end else begin
            word_cnt_d = word_cnt_q + WORD_COUNT_WIDTH'(1);
          end
        end
      end
      DROP: begin
        // Gap length was captured on the truncated beat.
        if (src_valid && src_last) state_d = (gap_cnt_q == '0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt_q <= GAP_WIDTH'(1)) state_d = IDLE;
        else                            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      rr_q          <= 1'b0;
      word_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      frame_count_q <= '0;
      err_long_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_q          <= rr_d;
      word_cnt_q    <= word_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_count_q <= frame_count_d;
      err_long_q    <= err_long_d;
    end
  end

endmodule

// File: tb/tb_rvvi_tx_arbiter.sv
// Directed/randomized bench for rvvi_tx_arbiter; expected MAC beats come from per-source
// frame models built as each word is offered.
module tb_rvvi_tx_arbiter;

  localparam int MAX = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] s0_wdata = '0, s1_wdata = '0, mw_data;
  logic [3:0]  s0_wstrb = '0, s1_wstrb = '0, mw_strb;
  logic        s0_wlast = 1'b0, s0_wvalid = 1'b0, s0_wready;
  logic        s1_wlast = 1'b0, s1_wvalid = 1'b0, s1_wready;
  logic        mw_last, mw_valid, mw_ready = 1'b1;
  logic [31:0] ifg = '0;
  logic        err_clear = 1'b0;
  logic [1:0]  grant;
  logic [63:0] frame_count;
  logic        err_long;

  rvvi_tx_arbiter #(
    .MAX_FRAME_WORDS  (MAX),
    .WORD_COUNT_WIDTH (10),
    .FRAME_COUNT_WIDTH(64),
    .GAP_WIDTH        (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .S0Wdata      (s0_wdata),
    .S0Wstrb      (s0_wstrb),
    .S0Wlast      (s0_wlast),
    .S0Wvalid     (s0_wvalid),
    .S0Wready     (s0_wready),
    .S1Wdata      (s1_wdata),
    .S1Wstrb      (s1_wstrb),
    .S1Wlast      (s1_wlast),
    .S1Wvalid     (s1_wvalid),
    .S1Wready     (s1_wready),
    .MWdata       (mw_data),
    .MWstrb       (mw_strb),
    .MWlast       (mw_last),
    .MWvalid      (mw_valid),
    .MWready      (mw_ready),
    .InterFrameGap(ifg),
    .ErrClear     (err_clear),
    .Grant        (grant),
    .FrameCount   (frame_count),
    .ErrLong      (err_long)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [36:0] exp0[$], exp1[$];
  logic [63:0] fc_exp = 0;
  bit          abort = 1'b0;

  // Observed traffic.
  logic [36:0] mac0[$], mac1[$];
  logic [1:0]  gq[$];
  int          gap_q[$];
  int          cyc = 0, t_last = 0, beats = 0, bad_beats = 0, acc0 = 0, rdy_bad = 0;
  logic [1:0]  prev_grant = 2'b00;
  bit          chk_rdy = 1'b0;
  bit          tog_done = 1'b0;

  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_grant <= grant;
    if (mw_valid && mw_ready) begin
      beats <= beats + 1;
      if (grant == 2'b01)      mac0.push_back({mw_data, mw_strb, mw_last});
      else if (grant == 2'b10) mac1.push_back({mw_data, mw_strb, mw_last});
      else                     bad_beats <= bad_beats + 1;
      if (mw_last) begin
        t_last <= cyc;
        gq.push_back(grant);
      end
    end
    if (grant != 2'b00 && prev_grant == 2'b00) gap_q.push_back(cyc - t_last);
    if (s0_wvalid && s0_wready) acc0 <= acc0 + 1;
    if (chk_rdy && grant == 2'b10 && (s1_wready !== mw_ready || s0_wready !== 1'b0))
      rdy_bad <= rdy_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Offer an n-word frame from one source; the MAC sees at most MAX words, last forced at MAX.
  task automatic send(input int src, input int n);
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      s = 4'($urandom);
      l = (i == n - 1);
      if (src == 0) begin
        s0_wdata = d; s0_wstrb = s; s0_wlast = l; s0_wvalid = 1'b1;
      end else begin
        s1_wdata = d; s1_wstrb = s; s1_wlast = l; s1_wvalid = 1'b1;
      end
      if (i < MAX) begin
        if (src == 0) exp0.push_back({d, s, l || (i == MAX - 1)});
        else          exp1.push_back({d, s, l || (i == MAX - 1)});
      end
      forever begin
        @(negedge clk);
        if (abort) break;
        if ((src == 0) ? s0_wready : s1_wready) break;
      end
      if (abort) begin
        s0_wvalid = 1'b0;
        s1_wvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    if (src == 0) begin
      s0_wvalid = 1'b0; s0_wlast = 1'b0; fc_exp++;
    end else begin
      s1_wvalid = 1'b0; s1_wlast = 1'b0;
    end
  endtask

  task automatic cmp_q(input string tag);
    int bad;
    check({tag, "_n0"}, 64'(mac0.size()), 64'(exp0.size()));
    bad = 0;
    for (int i = 0; i < mac0.size() && i < exp0.size(); i++) if (mac0[i] !== exp0[i]) bad++;
    check({tag, "_data0"}, 64'(bad), 64'd0);
    check({tag, "_n1"}, 64'(mac1.size()), 64'(exp1.size()));
    bad = 0;
    for (int i = 0; i < mac1.size() && i < exp1.size(); i++) if (mac1[i] !== exp1[i]) bad++;
    check({tag, "_data1"}, 64'(bad), 64'd0);
    mac0.delete(); mac1.delete(); exp0.delete(); exp1.delete();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] g_obs, g_exp;
    int          gbad, a0, b0;

    // Reset values while reset is held.
    #2;
    check("rst_mwvalid", 64'(mw_valid), 64'd0);
    check("rst_mwlast",  64'(mw_last),  64'd0);
    check("rst_s0ready", 64'(s0_wready), 64'd0);
    check("rst_s1ready", 64'(s1_wready), 64'd0);
    check("rst_grant",   64'(grant), 64'd0);
    check("rst_fc",      frame_count, 64'd0);
    check("rst_err",     64'(err_long), 64'd0);
    #18 reset_n = 1'b1;
    idle_cycles(2);

    // Single 20-word source-0 frame.
    send(0, 20);
    cmp_q("t1");
    check("t1_fc", frame_count, fc_exp);
    check("t1_grant_beats", 64'(bad_beats), 64'd0);
    idle_cycles(3);

    // Both sources contend, 3 x 4-word frames each.
    gq.delete(); gap_q.delete();
    fork
      begin send(0, 4); send(0, 4); send(0, 4); end
      begin send(1, 4); send(1, 4); send(1, 4); end
    join
    idle_cycles(3);
    check("t2_nframes", 64'(gq.size()), 64'd6);
    g_obs = '0; g_exp = '0;
    for (int k = 0; k < 6; k++) begin
      if (k < gq.size()) g_obs[2*k +: 2] = gq[k];
`ifdef RVVI_TX_PRIO_EN
      g_exp[2*k +: 2] = (k < 3) ? 2'b10 : 2'b01;
`else
      g_exp[2*k +: 2] = (k % 2 == 0) ? 2'b10 : 2'b01;
`endif
    end
    check("t2_order", 64'(g_obs), 64'(g_exp));
    check("t2_fc", frame_count, fc_exp);
    gbad = 0;
    for (int k = 1; k < gap_q.size(); k++) if (gap_q[k] != 2) gbad++;
    check("t2_ngrants", 64'(gap_q.size()), 64'd6);
    check("t2_gap0", 64'(gbad), 64'd0);
    cmp_q("t2");

    // Gap of 5 between back-to-back frames; mid-gap change must not matter.
    ifg = 32'd5;
    gq.delete(); gap_q.delete();
    fork
      begin send(0, 6); send(0, 6); end
      begin
        for (int w = 0; w < 200 && gq.size() == 0; w++) @(negedge clk);
        @(posedge clk); @(posedge clk); #1 ifg = 32'd100;
        for (int w = 0; w < 200 && grant == 2'b00; w++) @(negedge clk);
        ifg = 32'd5;
      end
    join
    idle_cycles(10);
    ifg = 32'd0;
    check("t3_ngrants", 64'(gap_q.size()), 64'd2);
    check("t3_gap", 64'((gap_q.size() > 1) ? gap_q[1] : -1), 64'd7);
    check("t3_fc", frame_count, fc_exp);
    cmp_q("t3");

    // Runaway 600-word frame is truncated at MAX.
    a0 = acc0;
    send(0, 600);
    idle_cycles(1);
    cmp_q("t4");
    check("t4_accepted", 64'(acc0 - a0), 64'd600);
    check("t4_err", 64'(err_long), 64'd1);
    check("t4_fc", frame_count, fc_exp);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    check("t4_err_clr", 64'(err_long), 64'd0);

    // MAC back-pressure toggling every cycle during a source-1 frame.
    chk_rdy = 1'b1;
    tog_done = 1'b0;
    fork
      begin send(1, 10); tog_done = 1'b1; end
      begin
        while (!tog_done) begin
          @(posedge clk);
          #1 mw_ready = ~mw_ready;
        end
        mw_ready = 1'b1;
      end
    join
    chk_rdy = 1'b0;
    idle_cycles(2);
    cmp_q("t5");
    check("t5_ready_mirror", 64'(rdy_bad), 64'd0);
    check("t5_fc", frame_count, fc_exp);

    // Asynchronous reset mid-frame.
    b0 = beats;
    fork
      send(0, 20);
      begin
        for (int w = 0; w < 200; w++) begin
          @(negedge clk);
          #1;
          if (beats >= b0 + 7) break;
        end
        #1 reset_n = 1'b0;
        abort = 1'b1;
        #1;
        check("t6_mwvalid", 64'(mw_valid), 64'd0);
        check("t6_grant", 64'(grant), 64'd0);
        check("t6_s0ready", 64'(s0_wready), 64'd0);
        check("t6_fc", frame_count, 64'd0);
      end
    join
    @(negedge clk);
    reset_n = 1'b1;
    abort = 1'b0;
    mac0.delete(); mac1.delete(); exp0.delete(); exp1.delete();
    fc_exp = 0;
    idle_cycles(2);
    send(0, 8);
    idle_cycles(1);
    cmp_q("t6");
    check("t6_fc_after", frame_count, fc_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
